// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end.
//   XLEN              : architectural register / address width
//   RESET_PC_DEFAULT  : default PC loaded by reset
//   fetch_state_e     : fetch sequencer FSM encoding
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StReq  = 2'd1,
    StPend = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-PC select for the fetch stage.
// Priority: branch > jump > sequential (pc + PC_STEP, modulo 2^XLEN).
// Ports:
//   pc_i             : current PC
//   branch_taken_i   : branch redirect request
//   branch_target_i  : branch destination
//   jump_i           : jump redirect request
//   jump_target_i    : jump destination
//   redirect_o       : any redirect this cycle
//   pc_next_o        : selected next PC
module fetch_pc_next
  import mips_pkg::*;
#(
  parameter int unsigned PC_STEP = 4
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] branch_target_i,
  input  logic            jump_i,
  input  logic [XLEN-1:0] jump_target_i,
  output logic            redirect_o,
  output logic [XLEN-1:0] pc_next_o
);

  assign redirect_o = branch_taken_i | jump_i;

  always_comb begin
    pc_next_o = pc_i + XLEN'(PC_STEP);
    if (branch_taken_i) begin
      pc_next_o = branch_target_i;
    end else if (jump_i) begin
      pc_next_o = jump_target_i;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, drives the instruction-memory
// request/ack handshake, applies branch/jump redirects and hazard stalls,
// and delivers instruction/PC pairs to the IF/ID boundary. A one-entry
// pending buffer catches a response that lands while the stage is stalled.
// Optional feature macro: FETCH_PERF_EN adds 32-bit performance counters.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   stall                    : hold IF/ID and block new issue
//   branch_taken/_target     : highest-priority redirect
//   jump/jump_target         : redirect, ignored under branch_taken
//   imem_req/imem_addr       : memory request (addr stable while req)
//   imem_ack/imem_rdata      : memory response
//   pc                       : address of the next fetch to issue
//   if_valid/if_instr/if_pc  : IF/ID slot
//   perf_*                   : counters (FETCH_PERF_EN only)
module fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
`ifdef FETCH_PERF_EN
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_redirects,
  output logic [31:0]     perf_stall_cycles
`else
  output logic [XLEN-1:0] if_pc
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] pend_instr_q, pend_instr_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;

  logic            redirect;
  logic [XLEN-1:0] pc_next;
  logic            deliver;

  fetch_pc_next #(
    .PC_STEP(PC_STEP)
  ) u_pc_next (
    .pc_i           (pc_q),
    .branch_taken_i (branch_taken),
    .branch_target_i(branch_target),
    .jump_i         (jump),
    .jump_target_i  (jump_target),
    .redirect_o     (redirect),
    .pc_next_o      (pc_next)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    kill_d       = kill_q;
    pend_instr_d = pend_instr_q;
    pend_pc_d    = pend_pc_q;
    deliver      = 1'b0;

    unique case (state_q)
      StBoot: begin
        if (redirect) begin
          pc_d       = pc_next;
          addr_d     = pc_next;
          if_valid_d = 1'b0;
          state_d    = StReq;
        end else if (!stall) begin
          addr_d     = pc_q;
          if_valid_d = 1'b0;
          state_d    = StReq;
        end
      end

      StReq: begin
        if (redirect) begin
          pc_d       = pc_next;
          if_valid_d = 1'b0;
          if (imem_ack) begin
            // In-flight word is stale; target can issue immediately.
            kill_d = 1'b0;
            addr_d = pc_next;
          end else begin
            // Request must stay up until acked; drop its word when it lands.
            kill_d = 1'b1;
          end
        end else if (imem_ack) begin
          if (kill_q) begin
            kill_d = 1'b0;
            if (!stall) begin
              addr_d     = pc_q;
              if_valid_d = 1'b0;
            end else begin
              state_d = StBoot;
            end
          end else if (!stall) begin
            deliver    = 1'b1;
            if_valid_d = 1'b1;
            if_instr_d = imem_rdata;
            if_pc_d    = addr_q;
            pc_d       = pc_next;
            addr_d     = pc_next;
          end else begin
            pend_instr_d = imem_rdata;
            pend_pc_d    = addr_q;
            pc_d         = pc_next;
            state_d      = StPend;
          end
        end else if (!stall) begin
          if_valid_d = 1'b0;
        end
      end

      StPend: begin
        if (redirect) begin
          pc_d         = pc_next;
          addr_d       = pc_next;
          if_valid_d   = 1'b0;
          pend_instr_d = '0;
          pend_pc_d    = '0;
          state_d      = StReq;
        end else if (!stall) begin
          deliver      = 1'b1;
          if_valid_d   = 1'b1;
          if_instr_d   = pend_instr_q;
          if_pc_d      = pend_pc_q;
          pend_instr_d = '0;
          pend_pc_d    = '0;
          addr_d       = pc_q;
          state_d      = StReq;
        end
      end

      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StBoot;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
      kill_q       <= 1'b0;
      pend_instr_q <= '0;
      pend_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      kill_q       <= kill_d;
      pend_instr_q <= pend_instr_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  assign imem_req  = (state_q == StReq);
  assign imem_addr = addr_q;
  assign pc        = pc_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_redirects_q, perf_redirects_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d   = perf_fetched_q + {31'd0, deliver};
    perf_redirects_d = perf_redirects_q + {31'd0, redirect};
    perf_stall_d     = perf_stall_q + {31'd0, stall};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q   <= '0;
      perf_redirects_q <= '0;
      perf_stall_q     <= '0;
    end else begin
      perf_fetched_q   <= perf_fetched_d;
      perf_redirects_q <= perf_redirects_d;
      perf_stall_q     <= perf_stall_d;
    end
  end

  assign perf_fetched      = perf_fetched_q;
  assign perf_redirects    = perf_redirects_q;
  assign perf_stall_cycles = perf_stall_q;
`else
  logic unused_deliver;
  assign unused_deliver = deliver;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int n_checks;
  int n_fail;

  fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .pc           (pc),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content model: each word is a simple function of its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, " imem_req"}, {31'd0, imem_req}, 32'd0);
    check_eq({tag, " imem_addr"}, imem_addr, 32'h0);
    check_eq({tag, " pc"}, pc, 32'h0);
    check_eq({tag, " if_valid"}, {31'd0, if_valid}, 32'd0);
    check_eq({tag, " if_instr"}, if_instr, 32'h0);
    check_eq({tag, " if_pc"}, if_pc, 32'h0);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    jump          = 1'b0;
    jump_target   = 32'h0;
    imem_ack      = 1'b0;
    tick();
    tick();
    check_reset_state("reset");

    // Zero-wait memory: one instruction per cycle.
    rst      = 1'b0;
    imem_ack = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      check_eq("zw imem_req", {31'd0, imem_req}, 32'd1);
      check_eq("zw imem_addr", imem_addr, 32'(4 * k));
      if (k > 0) begin
        check_eq("zw if_valid", {31'd0, if_valid}, 32'd1);
        check_eq("zw if_pc", if_pc, 32'(4 * (k - 1)));
        check_eq("zw if_instr", if_instr, mem_word(32'(4 * (k - 1))));
      end
      tick();
    end

    // Ack delayed 3 cycles.
    rst      = 1'b1;
    imem_ack = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      check_eq("wait imem_req", {31'd0, imem_req}, 32'd1);
      check_eq("wait imem_addr", imem_addr, 32'h0);
      check_eq("wait if_valid", {31'd0, if_valid}, 32'd0);
      tick();
    end
    imem_ack = 1'b1;
    tick();
    check_eq("late if_valid", {31'd0, if_valid}, 32'd1);
    check_eq("late if_pc", if_pc, 32'h0);
    check_eq("late imem_addr", imem_addr, 32'h4);

    // Stall rises on the ack for 0x8.
    tick();
    check_eq("pre-stall imem_addr", imem_addr, 32'h8);
    stall = 1'b1;
    tick();
    check_eq("pend imem_req", {31'd0, imem_req}, 32'd0);
    check_eq("pend if_pc hold", if_pc, 32'h4);
    check_eq("pend if_valid hold", {31'd0, if_valid}, 32'd1);
    check_eq("pend pc", pc, 32'hC);
    imem_ack = 1'b0;
    tick();
    check_eq("pend2 if_pc hold", if_pc, 32'h4);
    check_eq("pend2 imem_req", {31'd0, imem_req}, 32'd0);
    stall = 1'b0;
    tick();
    check_eq("release if_pc", if_pc, 32'h8);
    check_eq("release if_instr", if_instr, mem_word(32'h8));
    check_eq("release if_valid", {31'd0, if_valid}, 32'd1);
    check_eq("release imem_req", {31'd0, imem_req}, 32'd1);
    check_eq("release imem_addr", imem_addr, 32'hC);

    // Branch while the request to 0x10 is outstanding.
    imem_ack = 1'b1;
    tick();
    check_eq("pre-br imem_addr", imem_addr, 32'h10);
    imem_ack      = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    tick();
    check_eq("kill imem_addr held", imem_addr, 32'h10);
    check_eq("kill imem_req", {31'd0, imem_req}, 32'd1);
    check_eq("kill pc", pc, 32'h100);
    check_eq("kill if_valid", {31'd0, if_valid}, 32'd0);
    branch_taken = 1'b0;
    imem_ack     = 1'b1;
    tick();
    check_eq("killed ack if_valid", {31'd0, if_valid}, 32'd0);
    check_eq("reissue imem_addr", imem_addr, 32'h100);
    tick();
    check_eq("target if_pc", if_pc, 32'h100);
    check_eq("target if_valid", {31'd0, if_valid}, 32'd1);
    check_eq("target if_instr", if_instr, mem_word(32'h100));
    check_eq("target next addr", imem_addr, 32'h104);

    // Branch and jump together: branch wins.
    branch_taken  = 1'b1;
    branch_target = 32'h200;
    jump          = 1'b1;
    jump_target   = 32'h300;
    tick();
    check_eq("bj imem_addr", imem_addr, 32'h200);
    check_eq("bj pc", pc, 32'h200);
    check_eq("bj if_valid", {31'd0, if_valid}, 32'd0);
    branch_taken = 1'b0;
    jump         = 1'b0;
    tick();
    check_eq("bj if_pc", if_pc, 32'h200);
    check_eq("bj deliver valid", {31'd0, if_valid}, 32'd1);

    // Redirect during stall still flushes.
    stall       = 1'b1;
    jump        = 1'b1;
    jump_target = 32'h400;
    tick();
    check_eq("stall-redir if_valid", {31'd0, if_valid}, 32'd0);
    check_eq("stall-redir imem_addr", imem_addr, 32'h400);
    stall = 1'b0;
    jump  = 1'b0;
    tick();
    check_eq("stall-redir if_pc", if_pc, 32'h400);

    // PC wrap at the top of the address space.
    jump        = 1'b1;
    jump_target = 32'hFFFF_FFFC;
    tick();
    check_eq("wrap imem_addr", imem_addr, 32'hFFFF_FFFC);
    jump = 1'b0;
    tick();
    check_eq("wrap if_pc", if_pc, 32'hFFFF_FFFC);
    check_eq("wrap next addr", imem_addr, 32'h0);
    check_eq("wrap pc", pc, 32'h0);
    tick();
    check_eq("post-wrap imem_addr", imem_addr, 32'h4);

    // Reset mid-request, then a late ack that must be ignored.
    imem_ack = 1'b0;
    rst      = 1'b1;
    tick();
    check_reset_state("mid-req reset");
    rst      = 1'b0;
    stall    = 1'b1;
    imem_ack = 1'b1;
    tick();
    check_eq("late ack imem_req", {31'd0, imem_req}, 32'd0);
    check_eq("late ack if_valid", {31'd0, if_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage sequencer for the MIPS pipeline. Owns the program counter and drives the instruction-memory request handshake. Applies branch/jump redirects from later stages and stall requests from the hazard unit. Delivers fetched instruction/PC pairs into the IF/ID boundary with a one-entry pending buffer for responses that arrive during a stall.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded by reset.
- `PC_STEP`, default 4: sequential PC increment in bytes.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hazard unit holds IF/ID outputs and blocks new issue.
- `branch_taken` in 1: redirect to `branch_target`; highest-priority redirect.
- `branch_target` in 32: branch destination.
- `jump` in 1: redirect to `jump_target`; ignored when `branch_taken` is high.
- `jump_target` in 32: jump destination.
- `imem_req` out 1: instruction memory request.
- `imem_addr` out 32: request address, stable while `imem_req` is high.
- `imem_ack` in 1: response valid; completes the outstanding request.
- `imem_rdata` in 32: instruction word, valid with `imem_ack`.
- `pc` out 32: address of the next fetch to be issued.
- `if_valid` out 1: IF/ID slot holds a real instruction.
- `if_instr` out 32: fetched instruction.
- `if_pc` out 32: address of `if_instr`.

## Operation
- FSM states: BOOT, REQ, PEND.
- Reset (`rst`=1) is checked before everything else. It sets state to BOOT, `pc`=`RESET_PC`, `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_instr`=0, `if_pc`=0, and clears the kill flag and pending buffer. A reset mid-request abandons the request, and the late `imem_ack` is ignored in BOOT.
- BOOT:
  - When `stall`=0: latch `imem_addr`=`pc` and go to REQ.
  - Otherwise stay in BOOT.
- REQ: `imem_req`=1 and `imem_addr` is held until `imem_ack`.
  - Ack with kill flag set: discard the word and clear kill. If `stall`=0, re-issue at `pc`; otherwise go to BOOT.
  - Ack with `stall`=0 and no redirect: `if_instr`=`imem_rdata`, `if_pc`=`imem_addr`, `if_valid`=1, `pc`=`pc`+`PC_STEP`. Issue at the new `pc` the next cycle and stay in REQ.
  - Ack with `stall`=1: store the word and its address in the pending buffer, set `pc`=`pc`+`PC_STEP`, go to PEND, and drop `imem_req`.
- PEND: `imem_req`=0.
  - When `stall` falls: move the pending entry to the IF/ID outputs and go to BOOT-equivalent issue (REQ at `pc`).
- Redirect (`branch_taken` or `jump`):
  - Overrides `stall` and flushes: `if_valid`=0 and the pending buffer is cleared.
  - `pc` is set to the target.
  - In REQ without a same-cycle ack: set kill.
  - In REQ with a same-cycle ack: discard the word, no kill.
  - Then re-issue at the target.
- `stall`=1 without redirect holds `if_valid`, `if_instr` and `if_pc`.
- `stall`=0 with no delivery this cycle writes `if_valid`=0 (bubble).
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0. Targets are taken as-is, with no alignment check.

## Timing
- Zero-wait memory (`imem_ack` in the same cycle as `imem_req`) sustains one instruction per cycle.
- Latency from request to IF/ID outputs: the outputs are registered on the ack edge, visible the next cycle.
- Redirect penalty: first target instruction appears at IF/ID no earlier than 2 cycles after the redirect cycle.
- At most one outstanding request; `imem_req` never drops before `imem_ack` except on reset.

## Configuration
- `FETCH_PERF_EN` defined: adds outputs `perf_fetched[31:0]`, `perf_redirects[31:0]`, `perf_stall_cycles[31:0]`.
  - `perf_fetched` counts delivered instructions.
  - `perf_redirects` counts redirect cycles.
  - `perf_stall_cycles` counts cycles with `stall`=1.
  - All three clear on `rst` and wrap at 2^32.
- `FETCH_PERF_EN` undefined: the ports and counters are absent and core behaviour is identical.

## Structure
- Shared package `mips_pkg` holds:
  - FSM state encoding (BOOT=2'd0, REQ=2'd1, PEND=2'd2).
  - the default `RESET_PC`;
  - the `XLEN`=32 constant.
- Sub-module `fetch_pc_next`: combinational next-PC select with priority branch > jump > sequential, plus the increment. Instantiated once.

## Test plan
- Reset then release with zero-wait ack: `imem_addr` steps 0,4,8,12 and `if_pc` follows one cycle behind, with `if_valid`=1 continuously.
- Ack delayed 3 cycles: `imem_req`=1 and `imem_addr`=0 are held stable, and `if_valid`=0 until the word arrives.
- `stall` rises in the same cycle an ack for 0x8 arrives: FSM goes to PEND and outputs hold. When `stall` drops, `if_pc`=0x8 and the next request is 0xC.
- `branch_taken` with target 0x100 while a request to 0x10 is pending: the ack for 0x10 is discarded, the next request is 0x100, `if_pc`=0x100, and no 0x10 is ever delivered.
- `branch_taken` and `jump` together (0x200 and 0x300): the fetch goes to 0x200. Redirect during `stall`=1 still flushes `if_valid` to 0.
- `pc` at 0xFFFF_FFFC with zero-wait ack: the next request is 0x0. Assert `rst` mid-request: all outputs return to reset values on the next edge.
